// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if
// Purpose: bundles the AXI read-address (AR) and read-data (R) channel
// signals that the read arbiter drives toward the AXI slave.
// Signals:
//   arid, araddr, arsize, arvalid   AR beat driven by the arbiter
//   arready                         AR acceptance from the slave
//   rid, rdata, rvalid              R beat driven by the slave
//   rready                          R acceptance from the arbiter
// Modports:
//   master  the arbiter side
//   slave   the AXI slave / interconnect side
interface axi_rd_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arsize, arvalid, rready,
    input  arready, rid, rdata, rvalid
  );

  modport slave (
    input  arid, araddr, arsize, arvalid, rready,
    output arready, rid, rdata, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
// Purpose: shares one AXI read channel pair between the core's SRAM-like
// instruction and data read ports. One AR beat is registered at a time,
// outstanding reads are counted per requester, R beats are routed back by
// rid, and data reads that hit the word of an in-flight write are held off.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   inst_req/addr/size    instruction read request (size 0=byte 1=half 2=word)
//   inst_addr_ok          instruction request accepted this cycle
//   inst_data_ok/rdata    instruction read data valid this cycle / the data
//   data_*                data read port, same shape as inst_*
//   wr_pending, wr_addr   a write accepted but not yet B-responded, and its address
//   axi                   AXI AR/R channels (master modport)
//   protocol_err          sticky flag: an R beat matched no outstanding read
module axi_rd_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_req,
  input  logic [31:0]      inst_addr,
  input  logic [1:0]       inst_size,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             data_req,
  input  logic [31:0]      data_addr,
  input  logic [1:0]       data_size,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  input  logic             wr_pending,
  input  logic [31:0]      wr_addr,
  axi_rd_arbiter_if.master axi,
  output logic             protocol_err
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [2:0]    CNT_MAX    = 3'(MAX_OUTSTANDING);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  // Registered AR slot
  logic        slot_valid_q, slot_valid_d;
  logic        slot_id_q, slot_id_d;
  logic [31:0] slot_addr_q, slot_addr_d;
  logic [1:0]  slot_size_q, slot_size_d;

  // Per-requester outstanding read counters and starvation tracking
  logic [2:0]    inst_cnt_q, inst_cnt_d;
  logic [2:0]    data_cnt_q, data_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;

  logic        protocol_err_q, protocol_err_d;
  logic [31:0] inst_rdata_q, inst_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  logic slot_free;
  logic inst_elig, data_elig, wr_hazard, force_inst;
  logic grant_inst, grant_data;
  logic r_fire, inst_ret, data_ret;

  // Only the word address matters for the write hazard.
  logic wr_addr_lo_unused;
  assign wr_addr_lo_unused = ^wr_addr[1:0];

  // The slot can take a new beat when empty or when its beat leaves this
  // cycle, which allows back-to-back AR issue.
  assign slot_free  = ~slot_valid_q | axi.arready;
  assign inst_elig  = inst_req & (inst_cnt_q < CNT_MAX);
  assign wr_hazard  = wr_pending & (data_addr[31:2] == wr_addr[31:2]);
  assign data_elig  = data_req & (data_cnt_q < CNT_MAX) & ~wr_hazard;
  assign force_inst = (starve_cnt_q == STARVE_MAX) & inst_elig;

  // Data normally wins; inst wins once data has been favoured too often.
  // Grants are suppressed while reset is held.
  assign grant_inst = ~reset & slot_free & inst_elig & (~data_elig | force_inst);
  assign grant_data = ~reset & slot_free & data_elig & ~force_inst;

  // rready follows reset directly so no beat is consumed during reset.
  assign axi.rready = ~reset;
  assign r_fire     = axi.rvalid & axi.rready;
  assign inst_ret   = r_fire & (axi.rid == 4'd0) & (inst_cnt_q != 3'd0);
  assign data_ret   = r_fire & (axi.rid == 4'd1) & (data_cnt_q != 3'd0);

  // Next-state logic for the slot, counters, starvation count, error flag
  // and held read data.
  always_comb begin
    slot_valid_d   = slot_valid_q;
    slot_id_d      = slot_id_q;
    slot_addr_d    = slot_addr_q;
    slot_size_d    = slot_size_q;
    inst_cnt_d     = inst_cnt_q;
    data_cnt_d     = data_cnt_q;
    starve_cnt_d   = starve_cnt_q;
    protocol_err_d = protocol_err_q;
    inst_rdata_d   = inst_rdata_q;
    data_rdata_d   = data_rdata_q;

    // Fields are only rewritten on a grant, so they stay stable while the
    // slave stalls the beat.
    if (grant_inst | grant_data) begin
      slot_valid_d = 1'b1;
      slot_id_d    = grant_data;
      slot_addr_d  = grant_data ? data_addr : inst_addr;
      slot_size_d  = grant_data ? data_size : inst_size;
    end else if (axi.arready) begin
      slot_valid_d = 1'b0;
    end

    inst_cnt_d = inst_cnt_q + {2'b00, grant_inst} - {2'b00, inst_ret};
    data_cnt_d = data_cnt_q + {2'b00, grant_data} - {2'b00, data_ret};

    if (~inst_req | grant_inst) begin
      starve_cnt_d = '0;
    end else if (grant_data & (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + SW'(1);
    end

    if (r_fire & ~inst_ret & ~data_ret) begin
      protocol_err_d = 1'b1;
    end

    if (inst_ret) begin
      inst_rdata_d = axi.rdata;
    end
    if (data_ret) begin
      data_rdata_d = axi.rdata;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid_q   <= 1'b0;
      slot_id_q      <= 1'b0;
      slot_addr_q    <= '0;
      slot_size_q    <= '0;
      inst_cnt_q     <= '0;
      data_cnt_q     <= '0;
      starve_cnt_q   <= '0;
      protocol_err_q <= 1'b0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
    end else begin
      slot_valid_q   <= slot_valid_d;
      slot_id_q      <= slot_id_d;
      slot_addr_q    <= slot_addr_d;
      slot_size_q    <= slot_size_d;
      inst_cnt_q     <= inst_cnt_d;
      data_cnt_q     <= data_cnt_d;
      starve_cnt_q   <= starve_cnt_d;
      protocol_err_q <= protocol_err_d;
      inst_rdata_q   <= inst_rdata_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = inst_ret;
  assign data_data_ok = data_ret;
  // Routed data is visible in the beat's own cycle and held afterwards.
  assign inst_rdata   = inst_rdata_d;
  assign data_rdata   = data_rdata_d;

  assign axi.arvalid  = slot_valid_q;
  assign axi.arid     = {3'b000, slot_id_q};
  assign axi.araddr   = slot_addr_q;
  assign axi.arsize   = {1'b0, slot_size_q};
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
// Purpose: self-checking bench for axi_rd_arbiter. A behavioural reference
// model (queue of waiting AR beats, integer outstanding counts, integer
// starvation count) predicts every output each cycle; a small AXI slave
// model answers accepted AR beats in per-id order.
module tb_axi_rd_arbiter;
  localparam int MAX_OUT = 2;
  localparam int STARVE  = 4;

  logic        clk;
  logic        reset;
  logic        inst_req, data_req, wr_pending;
  logic [31:0] inst_addr, data_addr, wr_addr;
  logic [1:0]  inst_size, data_size;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        protocol_err;

  axi_rd_arbiter_if axi();

  axi_rd_arbiter #(.MAX_OUTSTANDING(MAX_OUT), .STARVE_LIMIT(STARVE)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_size    (inst_size),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_addr    (data_addr),
    .data_size    (data_size),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .wr_pending   (wr_pending),
    .wr_addr      (wr_addr),
    .axi          (axi),
    .protocol_err (protocol_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          id;
    logic [31:0] addr;
    logic [1:0]  size;
  } ar_beat_t;

  // Reference model state
  ar_beat_t    ar_wait[$];
  int          out_cnt[2];
  int          starve;
  bit          err_flag;
  logic [31:0] last_rdata[2];
  bit          have_rdata[2];
  // Slave model: accepted AR beats not yet answered, per id
  int          slave_pend[2];

  int checks;
  int errors;
  int force_events;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Predict this cycle's outputs from the model, compare, then advance the
  // model and the slave to the state after the coming clock edge.
  task automatic evaluateCycle();
    bit in_rst, free, i_el, d_el, haz, force_i, g_i, g_d, fire, r_i, r_d;
    ar_beat_t b;
    in_rst  = reset;
    free    = (ar_wait.size() == 0) || axi.arready;
    i_el    = inst_req && (out_cnt[0] < MAX_OUT);
    haz     = wr_pending && (data_addr[31:2] == wr_addr[31:2]);
    d_el    = data_req && (out_cnt[1] < MAX_OUT) && !haz;
    force_i = (starve == STARVE) && i_el;
    g_i     = !in_rst && free && i_el && (!d_el || force_i);
    g_d     = !in_rst && free && d_el && !force_i;
    fire    = !in_rst && axi.rvalid;
    r_i     = fire && (axi.rid == 4'd0) && (out_cnt[0] > 0);
    r_d     = fire && (axi.rid == 4'd1) && (out_cnt[1] > 0);

    checkOutput("inst_addr_ok", 32'(inst_addr_ok), 32'(g_i));
    checkOutput("data_addr_ok", 32'(data_addr_ok), 32'(g_d));
    checkOutput("inst_data_ok", 32'(inst_data_ok), 32'(r_i));
    checkOutput("data_data_ok", 32'(data_data_ok), 32'(r_d));
    checkOutput("rready", 32'(axi.rready), 32'(!in_rst));
    if (r_i) checkOutput("inst_rdata", inst_rdata, axi.rdata);
    else if (have_rdata[0]) checkOutput("inst_rdata_hold", inst_rdata, last_rdata[0]);
    if (r_d) checkOutput("data_rdata", data_rdata, axi.rdata);
    else if (have_rdata[1]) checkOutput("data_rdata_hold", data_rdata, last_rdata[1]);
    if (!in_rst) begin
      checkOutput("arvalid", 32'(axi.arvalid), 32'(ar_wait.size() != 0));
      if (ar_wait.size() != 0) begin
        b = ar_wait[0];
        checkOutput("arid", 32'(axi.arid), 32'(b.id));
        checkOutput("araddr", axi.araddr, b.addr);
        checkOutput("arsize", 32'(axi.arsize), 32'({1'b0, b.size}));
      end
      checkOutput("protocol_err", 32'(protocol_err), 32'(err_flag));
    end

    if (axi.arvalid === 1'b1 && axi.arready === 1'b1 && axi.arid <= 4'd1)
      slave_pend[axi.arid[0]]++;
    if (fire && axi.rid <= 4'd1 && slave_pend[axi.rid[0]] > 0)
      slave_pend[axi.rid[0]]--;

    if (in_rst) begin
      ar_wait.delete();
      out_cnt    = '{0, 0};
      starve     = 0;
      err_flag   = 1'b0;
      have_rdata = '{1'b0, 1'b0};
    end else begin
      if (ar_wait.size() != 0 && axi.arready) void'(ar_wait.pop_front());
      if (g_i) ar_wait.push_back('{1'b0, inst_addr, inst_size});
      if (g_d) ar_wait.push_back('{1'b1, data_addr, data_size});
      out_cnt[0] += int'(g_i) - int'(r_i);
      out_cnt[1] += int'(g_d) - int'(r_d);
      if (!inst_req || g_i) starve = 0;
      else if (g_d && starve < STARVE) starve++;
      if (fire && !r_i && !r_d) err_flag = 1'b1;
      if (r_i) begin last_rdata[0] = axi.rdata; have_rdata[0] = 1'b1; end
      if (r_d) begin last_rdata[1] = axi.rdata; have_rdata[1] = 1'b1; end
      if (g_i && force_i) force_events++;
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, check at the
  // falling edge, and return just after the next rising edge.
  task automatic applyStimulus(input bit rst, input bit ireq, input logic [31:0] iaddr,
                               input logic [1:0] isize, input bit dreq, input logic [31:0] daddr,
                               input logic [1:0] dsize, input bit wp, input logic [31:0] waddr,
                               input bit ardy, input bit rv, input logic [3:0] r_id,
                               input logic [31:0] rd);
    reset       = rst;
    inst_req    = ireq;
    inst_addr   = iaddr;
    inst_size   = isize;
    data_req    = dreq;
    data_addr   = daddr;
    data_size   = dsize;
    wr_pending  = wp;
    wr_addr     = waddr;
    axi.arready = ardy;
    axi.rvalid  = rv;
    axi.rid     = r_id;
    axi.rdata   = rd;
    @(negedge clk);
    evaluateCycle();
    @(posedge clk);
    #1;
  endtask

  // One random cycle; the slave only answers ids it has accepted beats for.
  task automatic randomCycle(input int p_ireq, input int p_dreq, input int p_ardy,
                             input int p_rv, input bit inst_ret_ok);
    logic [31:0] waddr, daddr;
    bit          wp, rv;
    logic [3:0]  r_id;
    logic [1:0]  lo;
    waddr = $urandom;
    wp    = ($urandom_range(0, 2) == 0);
    lo    = 2'($urandom_range(0, 3));
    daddr = ($urandom_range(0, 3) == 0) ? {waddr[31:2], lo} : $urandom;
    rv    = 1'b0;
    r_id  = 4'd0;
    if ($urandom_range(0, 99) < p_rv) begin
      if (slave_pend[1] > 0 && (slave_pend[0] == 0 || !inst_ret_ok || $urandom_range(0, 1) == 1)) begin
        rv = 1'b1; r_id = 4'd1;
      end else if (slave_pend[0] > 0 && inst_ret_ok) begin
        rv = 1'b1; r_id = 4'd0;
      end
    end
    applyStimulus(1'b0, $urandom_range(0, 99) < p_ireq, $urandom, 2'($urandom_range(0, 2)),
                  $urandom_range(0, 99) < p_dreq, daddr, 2'($urandom_range(0, 2)),
                  wp, waddr, $urandom_range(0, 99) < p_ardy, rv, r_id, $urandom);
  endtask

  // Let all issued reads complete, bounded so a stuck DUT cannot hang the run.
  task automatic drainAll(input string tag);
    int guard;
    bit rv;
    logic [3:0] r_id;
    guard = 0;
    while ((slave_pend[0] + slave_pend[1] > 0 || ar_wait.size() != 0) && guard < 100) begin
      rv   = (slave_pend[0] + slave_pend[1]) > 0;
      r_id = (slave_pend[1] > 0) ? 4'd1 : 4'd0;
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0,
                    1'b1, rv, r_id, $urandom);
      guard++;
    end
    checkOutput(tag, 32'(slave_pend[0] + slave_pend[1] + ar_wait.size()), 32'd0);
  endtask

  task automatic idleCycle(input bit rst);
    applyStimulus(rst, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0,
                  1'b0, 1'b0, 4'd0, 32'h0);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    force_events = 0;
    out_cnt      = '{0, 0};
    slave_pend   = '{0, 0};
    have_rdata   = '{1'b0, 1'b0};
    starve       = 0;
    err_flag     = 1'b0;
    reset = 1'b1; inst_req = 1'b0; data_req = 1'b0; wr_pending = 1'b0;
    inst_addr = '0; data_addr = '0; wr_addr = '0; inst_size = '0; data_size = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0;
    @(posedge clk);
    #1;

    // Reset with requests pending: nothing may be accepted.
    applyStimulus(1'b1, 1'b1, 32'h1000, 2'd2, 1'b1, 32'h2000, 2'd2, 1'b0, 32'h0,
                  1'b1, 1'b1, 4'd0, 32'h1234);
    idleCycle(1'b1);
    checkOutput("rst_arvalid", 32'(axi.arvalid), 32'd0);
    checkOutput("rst_arid", 32'(axi.arid), 32'd0);
    checkOutput("rst_araddr", axi.araddr, 32'd0);
    checkOutput("rst_arsize", 32'(axi.arsize), 32'd0);
    checkOutput("rst_perr", 32'(protocol_err), 32'd0);
    checkOutput("rst_rready", 32'(axi.rready), 32'd0);

    // Single instruction read.
    $display("[TB] single inst read");
    applyStimulus(1'b0, 1'b1, 32'hBFC0_0000, 2'd2, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0,
                  1'b1, 1'b0, 4'd0, 32'h0);
    checkOutput("single_arvalid", 32'(axi.arvalid), 32'd1);
    checkOutput("single_araddr", axi.araddr, 32'hBFC0_0000);
    checkOutput("single_arsize", 32'(axi.arsize), 32'd2);
    checkOutput("single_arid", 32'(axi.arid), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0,
                  1'b1, 1'b0, 4'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0,
                  1'b1, 1'b1, 4'd0, 32'h3C1D_0001);
    idleCycle(1'b0);
    checkOutput("single_rdata", inst_rdata, 32'h3C1D_0001);

    // Write hazard blocks the data read until the write completes.
    $display("[TB] write hazard");
    applyStimulus(1'b0, 1'b1, 32'h0040_0000, 2'd2, 1'b1, 32'h8000_1006, 2'd1, 1'b1, 32'h8000_1004,
                  1'b0, 1'b0, 4'd0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0040_0004, 2'd2, 1'b1, 32'h8000_1006, 2'd1, 1'b1, 32'h8000_1004,
                  1'b1, 1'b0, 4'd0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 32'h8000_1006, 2'd1, 1'b0, 32'h8000_1004,
                  1'b1, 1'b0, 4'd0, 32'h0);
    drainAll("drain_hazard");

    // AR backpressure: beat stays put, no new grant until arready.
    $display("[TB] AR backpressure");
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 32'h8000_2000, 2'd2, 1'b0, 32'h0,
                  1'b0, 1'b0, 4'd0, 32'h0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 32'h8000_2040, 2'd0, 1'b0, 32'h0,
                    1'b0, 1'b0, 4'd0, 32'h0);
    checkOutput("bp_araddr", axi.araddr, 32'h8000_2000);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 32'h8000_2040, 2'd0, 1'b0, 32'h0,
                  1'b1, 1'b0, 4'd0, 32'h0);
    drainAll("drain_bp");

    // Random mixed traffic.
    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) randomCycle(60, 60, 60, 50, 1'b1);
    drainAll("drain_random");

    // Heavy contention with slow inst returns to exercise the starvation override.
    $display("[TB] contention");
    for (int i = 0; i < 600; i++) randomCycle(100, 100, 100, 90, $urandom_range(0, 9) == 0);
    drainAll("drain_contention");
    $display("[TB] starvation overrides observed: %0d", force_events);

    // Unexpected responses.
    $display("[TB] bad responses");
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0,
                  1'b1, 1'b1, 4'd1, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0,
                  1'b1, 1'b1, 4'd3, 32'hCAFE_0003);
    for (int i = 0; i < 3; i++) idleCycle(1'b0);
    checkOutput("perr_sticky", 32'(protocol_err), 32'd1);
    idleCycle(1'b1);
    idleCycle(1'b0);
    checkOutput("perr_cleared", 32'(protocol_err), 32'd0);

    // Reset while a data read is in flight, then its late beat arrives.
    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b1, 32'h8000_3000, 2'd2, 1'b0, 32'h0,
                  1'b1, 1'b0, 4'd0, 32'h0);
    idleCycle(1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0,
                  1'b1, 1'b0, 4'd0, 32'h0);
    idleCycle(1'b1);
    idleCycle(1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0,
                  1'b1, 1'b1, 4'd1, 32'h5555_AAAA);
    idleCycle(1'b0);
    checkOutput("late_beat_perr", 32'(protocol_err), 32'd1);
    idleCycle(1'b1);
    idleCycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
